// File: rtl/lut_interp_fetch.sv
// -----------------------------------------------------------------------------
// lut_interp_fetch
//
// Front end of the piecewise-linear activation interpolator. It accepts one
// signed sample x and splits it into a table index (upper bits) and a
// fractional remainder (low FRAC_W bits). It then reads the activation table
// twice through a single-read-port interface, once at the index and once at
// index+1 (saturated). The triple {base, next_data, remaining} is presented
// over a valid/ready handshake. Only one sample is in flight at a time.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   in_valid     in_data is valid
//   in_data      signed sample x (DATA_W)
//   in_ready     block is in IDLE and can accept a sample
//   table_re     table read strobe
//   table_addr   table read address (IDX_W)
//   table_rdata  table read data, valid the cycle after table_re
//   out_valid    output triple is valid
//   out_ready    interpolator consumes the triple
//   base         table entry at the index
//   next_data    table entry at index+1, saturated at the top entry
//   remaining    zero-extended x[FRAC_W-1:0]
//
// Configuration macro
//   LUT_FETCH_SKIP_ZERO_EN  when defined, a sample whose remainder is 0 skips
//                           the second read. next_data is then loaded with
//                           base, and the latency drops from 3 to 2 edges.
// -----------------------------------------------------------------------------
module lut_interp_fetch #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [DATA_W-1:0]    in_data,
  output logic                        in_ready,
  output logic                        table_re,
  output logic [DATA_W-FRAC_W-1:0]    table_addr,
  input  logic signed [DATA_W-1:0]    table_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    base,
  output logic signed [DATA_W-1:0]    next_data,
  output logic signed [DATA_W-1:0]    remaining
);

  localparam int IDX_W = DATA_W - FRAC_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_BASE = 3'd1;
  localparam logic [2:0] S_RD_NEXT = 3'd2;
  localparam logic [2:0] S_CAPT    = 3'd3;
  localparam logic [2:0] S_OUT     = 3'd4;

  logic [2:0]               r_state;
  logic [2:0]               w_state_nxt;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [IDX_W-1:0]         r_table_addr;
  logic [IDX_W-1:0]         r_addr_next;
  logic signed [DATA_W-1:0] r_base;
  logic signed [DATA_W-1:0] r_next_data;
  logic [DATA_W-1:0]        r_remaining;

  logic [IDX_W-1:0]         w_addr_base;
  logic [IDX_W-1:0]         w_addr_next;
  logic [DATA_W-1:0]        w_remaining;
  logic                     w_accept;
  logic                     w_skip;

  // Adding the 2**(IDX_W-1) offset to the signed index is the same as
  // inverting its sign bit, so addresses span 0..2**IDX_W-1 without wrapping.
  assign w_addr_base = {~in_data[DATA_W-1], in_data[DATA_W-2:FRAC_W]};
  assign w_addr_next = (&w_addr_base) ? w_addr_base : w_addr_base + IDX_W'(1);
  assign w_remaining = {{IDX_W{1'b0}}, in_data[FRAC_W-1:0]};

  // r_in_ready is high only in IDLE, so this alone qualifies the accept.
  assign w_accept = in_valid & r_in_ready;

`ifdef LUT_FETCH_SKIP_ZERO_EN
  // A zero remainder makes next_data irrelevant to the interpolator, so the
  // second read is skipped.
  assign w_skip = (r_remaining[FRAC_W-1:0] == '0);
`else
  assign w_skip = 1'b0;
`endif

  // NOTE: every variable assigned in always_comb gets a default first, so that
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_nxt = S_RD_BASE;
      S_RD_BASE: w_state_nxt = S_RD_NEXT;
      S_RD_NEXT: w_state_nxt = w_skip ? S_OUT : S_CAPT;
      S_CAPT:    w_state_nxt = S_OUT;
      S_OUT:     if (out_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_table_addr <= '0;
      r_addr_next  <= '0;
      r_base       <= '0;
      r_next_data  <= '0;
      r_remaining  <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The handshake flags are registered decodes of the next state. This
      // keeps in_valid and out_ready off any combinational path to them.
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_OUT);

      if (w_accept) begin
        r_table_addr <= w_addr_base;
        r_addr_next  <= w_addr_next;
        r_remaining  <= w_remaining;
      end

      // The address moves only when another read follows. Otherwise it holds.
      if (r_state == S_RD_BASE && !w_skip) begin
        r_table_addr <= r_addr_next;
      end

      // Read data lags the strobe by one cycle. The base read returns in
      // RD_NEXT and the next read returns in CAPT.
      if (r_state == S_RD_NEXT) begin
        r_base <= table_rdata;
        if (w_skip) begin
          r_next_data <= table_rdata;
        end
      end

      if (r_state == S_CAPT) begin
        r_next_data <= table_rdata;
      end
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign table_re   = (r_state == S_RD_BASE) || ((r_state == S_RD_NEXT) && !w_skip);
  assign table_addr = r_table_addr;
  assign base       = r_base;
  assign next_data  = r_next_data;
  assign remaining  = r_remaining;

endmodule

// File: tb/tb_lut_interp_fetch.sv
// -----------------------------------------------------------------------------
// tb_lut_interp_fetch
//
// Self-checking bench for lut_interp_fetch. A registered-read table model
// T[i] = 8*i - 64 answers the table port. Expected triples, read addresses and
// latencies come from an arithmetic model of the index/remainder split
// (floor division of x by 2**FRAC_W). Honours LUT_FETCH_SKIP_ZERO_EN.
// -----------------------------------------------------------------------------
module tb_lut_interp_fetch;

  localparam int DATA_W = 8;
  localparam int FRAC_W = 4;
  localparam int IDX_W  = DATA_W - FRAC_W;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int SCALE  = 1 << FRAC_W;
`ifdef LUT_FETCH_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic                     clk;
  logic                     rst;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     table_re;
  logic [IDX_W-1:0]         table_addr;
  logic signed [DATA_W-1:0] table_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] next_data;
  logic signed [DATA_W-1:0] remaining;

  lut_interp_fetch #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .table_re    (table_re),
    .table_addr  (table_addr),
    .table_rdata (table_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .base        (base),
    .next_data   (next_data),
    .remaining   (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table model: registered read, with data one cycle after the strobe.
  logic signed [DATA_W-1:0] tbl [DEPTH];
  int rd_log[$];
  initial table_rdata = '0;
  always @(posedge clk) begin
    if (table_re) begin
      table_rdata <= tbl[table_addr];
      rd_log.push_back(int'(table_addr));
    end
  end

  int tests = 0;
  int fails = 0;

  typedef struct {
    int addr;
    int addr_n;
    int base;
    int nxt;
    int rem;
    int lat;
    int nreads;
  } exp_t;

  function automatic exp_t model(input logic [DATA_W-1:0] x);
    exp_t e;
    int xi;
    int idx;
    xi  = int'($signed(x));
    idx = (xi >= 0) ? xi / SCALE : -((-xi + SCALE - 1) / SCALE);
    e.rem    = xi - idx * SCALE;
    e.addr   = idx + DEPTH / 2;
    e.addr_n = (e.addr + 1 > DEPTH - 1) ? DEPTH - 1 : e.addr + 1;
    e.base   = 8 * e.addr - 64;
    if (SKIP && e.rem == 0) begin
      e.nxt = e.base; e.lat = 2; e.nreads = 1;
    end else begin
      e.nxt = 8 * e.addr_n - 64; e.lat = 3; e.nreads = 2;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic wait_in_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_wait", in_ready, 1);
  endtask

  // Entered and left at #1 after a rising edge. hold = cycles out_ready is
  // kept low after out_valid rises.
  task automatic run_sample(input logic [DATA_W-1:0] x, input int hold);
    exp_t e;
    int t0;
    e = model(x);
    wait_in_ready();
    rd_log.delete();
    in_valid  = 1'b1;
    in_data   = x;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    t0 = cyc;
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    check("in_ready_low_after_accept", in_ready, 0);
    while (out_valid !== 1'b1 && (cyc - t0) < 12) begin
      @(posedge clk); #1;
    end
    check("latency", cyc - t0, e.lat);
    check("base", base, e.base);
    check("next_data", next_data, e.nxt);
    check("remaining", remaining, e.rem);
    check("num_reads", rd_log.size(), e.nreads);
    if (rd_log.size() >= 1) check("rd_addr_base", rd_log[0], e.addr);
    if (rd_log.size() >= 2) check("rd_addr_next", rd_log[1], e.addr_n);
    if (hold > 0) begin
      repeat (hold) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = DATA_W'($urandom);
        @(posedge clk); #1;
        check("hold_out_valid", out_valid, 1);
        check("hold_base", base, e.base);
        check("hold_next", next_data, e.nxt);
        check("hold_rem", remaining, e.rem);
        check("hold_in_ready", in_ready, 0);
      end
      check("hold_no_reads", rd_log.size(), e.nreads);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("out_valid_drop", out_valid, 0);
    check("in_ready_return", in_ready, 1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) tbl[i] = DATA_W'(8 * i - 64);

    // Reset values.
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_table_re", table_re, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_table_addr", table_addr, 0);
    check("rst_base", base, 0);
    check("rst_next", next_data, 0);
    check("rst_rem", remaining, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("in_ready_first_edge", in_ready, 1);

    // Directed samples: mid table, top entry, bottom entry with zero remainder.
    run_sample(8'h25, 0);
    run_sample(8'h75, 0);
    run_sample(8'h80, 0);
    run_sample(8'hFF, 0);

    // Back-pressure: out_ready held low for 6 cycles, then a fresh sample.
    run_sample(8'h3A, 6);
    run_sample(8'hC7, 0);

    // Reset during RD_NEXT.
    wait_in_ready();
    in_valid  = 1'b1;
    in_data   = 8'h25;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    check("midrst_table_re", table_re, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    #2 rst = 1'b1;
    begin
      int seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1) seen++;
      end
      check("midrst_no_ghost_output", seen, 0);
    end
    run_sample(8'h25, 0);

    // Random samples with random short back-pressure.
    repeat (6) run_sample(DATA_W'($urandom), int'($urandom_range(0, 2)));

    // Back-to-back: in_valid held high, out_ready high.
    begin
      exp_t q[$];
      int   aq[$];
      exp_t e;
      int   n_acc = 0;
      int   guard = 0;
      int   last_acc = -1;
      int   last_lat = 0;
      bit   acc;
      wait_in_ready();
      in_data   = DATA_W'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while ((n_acc < 8 || q.size() > 0) && guard < 200) begin
        guard++;
        acc = 1'b0;
        @(negedge clk);
        if (out_valid === 1'b1) begin
          if (q.size() > 0) begin
            int ta;
            e  = q.pop_front();
            ta = aq.pop_front();
            check("b2b_latency", cyc - ta, e.lat);
            check("b2b_base", base, e.base);
            check("b2b_next", next_data, e.nxt);
            check("b2b_rem", remaining, e.rem);
          end else begin
            check("b2b_unexpected_output", 1, 0);
          end
        end
        if (in_ready === 1'b1 && in_valid) begin
          if (n_acc >= 8) begin
            in_valid = 1'b0;
          end else begin
            acc = 1'b1;
            e = model(in_data);
            q.push_back(e);
            aq.push_back(cyc + 1);
            if (last_acc >= 0) check("b2b_spacing", cyc + 1 - last_acc, last_lat + 2);
            last_acc = cyc + 1;
            last_lat = e.lat;
            n_acc++;
          end
        end
        @(posedge clk); #1;
        if (acc) in_data = DATA_W'($urandom);
      end
      in_valid = 1'b0;
      check("b2b_completed", (n_acc == 8 && q.size() == 0) ? 1 : 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lut_interp_fetch.md
# lut_interp_fetch

Front end for the piecewise-linear activation interpolator. It accepts one signed input sample, splits it into a table index and a fractional remainder, and performs two sequential reads of the activation table through a single-read-port table interface. It then presents `base`, `next_data` and `remaining` to the interpolator datapath over a valid/ready handshake. One instance sits in each hidden-layer activation function, between the neuron accumulator output and the interpolator.

## Interface
Parameters:
- `DATA_W`, default 8: width of the sample, the table entries and `remaining`.
- `FRAC_W`, default 4: number of low sample bits used as the remainder. This must match the interpolator's right shift.
- Derived: `IDX_W = DATA_W - FRAC_W` (4). The table depth is `2**IDX_W` (16).

Ports:
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `in_data` is valid.
- `in_data` input, signed `DATA_W`: input sample x.
- `in_ready` output, 1 bit: the block can accept a sample.
- `table_re` output, 1 bit: table read strobe.
- `table_addr` output, `IDX_W` bits: table read address.
- `table_rdata` input, signed `DATA_W`: table read data. It is valid in the cycle after the cycle in which `table_re` is high.
- `out_valid` output, 1 bit: the output triple is valid.
- `out_ready` input, 1 bit: the interpolator consumes the triple.
- `base` output, signed `DATA_W`: table entry at the index.
- `next_data` output, signed `DATA_W`: table entry at the index plus 1, clamped.
- `remaining` output, signed `DATA_W`: zero-extended `x[FRAC_W-1:0]`, range 0..15.

## Operation
- Index split:
  - `idx = x[DATA_W-1:FRAC_W]` is signed, range -8..7.
  - `addr_base = idx + 2**(IDX_W-1)`, which is `{~x[7], x[6:4]}` and spans 0..15.
  - `addr_next = addr_base + 1`, saturating at 15. At `addr_base == 15`, `next_data` equals `base`.
  - Address arithmetic never wraps.
- FSM states are IDLE, RD_BASE, RD_NEXT, CAPT and OUT.
  - **IDLE:** `in_ready` is 1. When `in_valid & in_ready`, latch `addr_base`, `addr_next` and `remaining`, then go to RD_BASE.
  - **RD_BASE:** `table_re` is 1 and `table_addr = addr_base`. Go to RD_NEXT.
  - **RD_NEXT:** `table_re` is 1 and `table_addr = addr_next`. Capture `table_rdata` into `base`. Go to CAPT.
  - **CAPT:** `table_re` is 0. Capture `table_rdata` into `next_data`. Go to OUT.
  - **OUT:** `out_valid` is 1 and the triple is held stable. When `out_ready` is 1, return to IDLE.
- Handshake rules:
  - `in_ready` is 0 in every state except IDLE, so there is only one sample in flight.
  - `in_data` is sampled only on the accepting edge and may change afterwards.
  - `out_valid` is never deasserted without `out_ready`.
  - The output registers are not modified while `out_valid` is 1.
- Outside RD_BASE and RD_NEXT, `table_re` is 0 and `table_addr` holds its last value.
- Reset values:
  - `in_ready` is 0. It rises at the first clock edge after reset release, with the state in IDLE.
  - `table_re` and `out_valid` are 0.
  - `table_addr`, `base`, `next_data` and `remaining` are 0.
- Reset asserted mid-operation drops the in-flight sample immediately and returns the block to IDLE.

## Timing
- Accepting edge t0. `table_re` is high in cycles t0 to t1 and t1 to t2. `base` is captured at t2 and `next_data` at t3.
- `out_valid` rises at t3, i.e. 3 edges after acceptance.
- If `out_ready` is already 1 in the first OUT cycle, `out_valid` drops at t4 and `in_ready` rises at t4.
- The next sample can therefore be accepted at the earliest at edge t5.
- Maximum throughput is one sample per 5 cycles.
- No combinational path exists from `in_valid`/`out_ready` to `out_valid`/`in_ready`. All outputs are registered or decoded from the state.

## Configuration
- Macro: `LUT_FETCH_SKIP_ZERO_EN`.
- **Defined:** if the latched `remaining` is 0, RD_NEXT does not assert `table_re`.
  - CAPT is skipped, and `next_data` is loaded with the `base` value in RD_NEXT.
  - `out_valid` rises 2 edges after acceptance.
  - Samples with `remaining` not equal to 0 behave exactly as in the undefined case.
- **Undefined:** every sample performs both reads, with fixed 3-edge latency.

## Test plan
- Table `T[i] = 8*i - 64`, x = 0x25 (idx 2, addr 10), `out_ready` held high:
  - reads at addr 10 then 11;
  - the output is `base` = 16, `next_data` = 24, `remaining` = 5;
  - `out_valid` rises 3 edges after acceptance.
- x = 0x75 (top entry): both reads are at addr 15, and `next_data` equals `base` = 56.
- x = 0x80 (-128): addr 0, `base` = -64, `next_data` = -56, `remaining` = 0. With `LUT_FETCH_SKIP_ZERO_EN` defined:
  - only one `table_re` pulse occurs;
  - `next_data` = -64;
  - latency is 2 edges.
- Hold `out_ready` = 0 for 6 cycles after `out_valid` rises:
  - `out_valid` and the triple stay stable;
  - `in_ready` stays 0;
  - `in_valid` pulses are ignored;
  - after `out_ready` goes high, the next sample is accepted.
- Assert `rst` low during RD_NEXT:
  - `table_re`, `out_valid` and `in_ready` go to 0 immediately;
  - after release, no output appears for the dropped sample;
  - a fresh sample x = 0x25 produces the same result as the first scenario.
- Back-to-back `in_valid` with `out_ready` high: samples are accepted every 5 cycles, and outputs appear in order with the correct values.
